// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared types and constants for the serial arithmetic blocks
//
// Purpose : FSM state encoding and operation-select constants used by
//           serial_addsub_ctrl and any other bit-serial arithmetic engine.
// Ports   : none (package).

package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } serial_state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage : arith_pkg

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
//
// Purpose : combinational one-bit full adder.
// Ports   : i_a, i_b  - addend bits
//           i_cin     - carry in
//           o_sum     - sum bit
//           o_cout    - carry out

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    logic w_half;

    assign w_half = i_a ^ i_b;
    assign o_sum  = w_half ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & w_half);

endmodule : full_adder

// File: rtl/serial_addsub_ctrl.sv
// rtl/serial_addsub_ctrl.sv - bit-serial add/subtract engine with valid/ready handshakes
//
// Purpose : sequences one full_adder over WIDTH cycles to produce A+B or A-B,
//           with carry-out and signed overflow.
// Ports   : clk, rst              - clock, async active-high reset
//           in_valid/in_ready     - operand handshake (a, b, sub)
//           out_valid/out_ready   - result handshake (result, cout, overflow)
//           busy                  - high while bits are being processed

module serial_addsub_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);

    import arith_pkg::*;

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    serial_state_t    r_state;
    serial_state_t    w_next_state;

    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_cout;
    logic             r_ovf;

    logic             w_sum;
    logic             w_fa_cout;
    logic             w_last;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_busy;

    full_adder u_fa (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_fa_cout)
    );

    assign w_last = (r_cnt == LAST_BIT);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath: operand shifters, result shifter, carry, counter, flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
                        r_a     <= a;
                        r_b     <= (sub == OP_ADD) ? b : ~b;
                        r_carry <= (sub == OP_SUB);
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    // LSB-first sums enter at the top, so after WIDTH shifts bit 0 is in place.
                    r_res   <= {w_sum, r_res[WIDTH-1:1]};
                    r_carry <= w_fa_cout;
                    if (w_last) begin
                        r_cout <= w_fa_cout;
                        // Signed overflow: carry into the MSB differs from carry out of it.
                        r_ovf  <= r_carry ^ w_fa_cout;
                    end else begin
                        r_cnt  <= r_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign busy      = w_busy;
    assign result    = r_res;
    assign cout      = r_cout;
    assign overflow  = r_ovf;

endmodule : serial_addsub_ctrl

// File: tb/tb_serial_addsub_ctrl.sv
// tb/tb_serial_addsub_ctrl.sv - self-checking bench for serial_addsub_ctrl

module tb_serial_addsub_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         sub = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;
    logic         busy;

    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         v;
    } exp_t;

    // Reference arithmetic from plain integer math and sign rules
    function automatic exp_t ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t        e;
        int unsigned xi;
        int unsigned yi;
        int unsigned full;
        xi = x;
        yi = y;
        if (!s) begin
            full  = xi + yi;
            e.res = W'(full);
            e.c   = (full >= (32'd1 << W));
            e.v   = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
        end else begin
            full  = xi - yi;
            e.res = W'(full);
            e.c   = (xi >= yi);
            e.v   = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
        end
        return e;
    endfunction

    // Transaction-level model state
    exp_t         q[$];
    bit           m_pend   = 1'b0;
    int           m_acc    = 0;
    logic [W-1:0] m_last   = '0;
    bit           last_acc = 1'b0;
    int           n_acc    = 0;
    int           n_done   = 0;
    int           n_abort  = 0;
    bit           e_ir;
    bit           e_ov;
    bit           e_busy;

    always @(negedge clk) begin
        if (rst) begin
            if (m_pend) n_abort++;
            m_pend   = 1'b0;
            q.delete();
            m_last   = '0;
            last_acc = 1'b0;
        end else begin
            e_ir   = !m_pend;
            e_ov   = m_pend && (cyc >= m_acc + W + 1);
            e_busy = m_pend && !e_ov;
            chk("in_ready", in_ready, e_ir);
            chk("out_valid", out_valid, e_ov);
            chk("busy", busy, e_busy);
            if (e_ir) chk("idle_result", result, m_last);
            if (e_ov && q.size() > 0) begin
                chk("result", result, q[0].res);
                chk("cout", cout, q[0].c);
                chk("overflow", overflow, q[0].v);
            end
            last_acc = 1'b0;
            if (in_valid && e_ir) begin
                q.push_back(ref_op(a, b, sub));
                m_pend   = 1'b1;
                m_acc    = cyc;
                n_acc++;
                last_acc = 1'b1;
            end
            if (e_ov && out_ready) begin
                if (q.size() > 0) begin
                    m_last = q[0].res;
                    void'(q.pop_front());
                end
                m_pend = 1'b0;
                n_done++;
            end
        end
    end

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        a = x; b = y; sub = s; in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("issue_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lows);
        bit got;
        got  = 1'b0;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                break;
            end
            lows++;
        end
        if (!got) chk("result_timeout", 0, 1);
    endtask

    task automatic release_result();
        @(posedge clk); #1; out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                          input logic [W-1:0] er, input logic ec, input logic ev);
        int   lows;
        exp_t m;
        m = ref_op(x, y, s);
        chk("model_res", m.res, er);
        chk("model_c", m.c, ec);
        chk("model_v", m.v, ev);
        issue(x, y, s);
        wait_valid(lows);
        chk("latency", lows, W);
        chk("lit_result", result, er);
        chk("lit_cout", cout, ec);
        chk("lit_overflow", overflow, ev);
        release_result();
    endtask

    int lows;
    int target;
    int issued;

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_cout", cout, 0);
        chk("rst_overflow", overflow, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed arithmetic
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Reset during RUN
        issue(8'h3C, 8'h15, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_result", result, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(8'h3C, 8'h15, 1'b0, 8'h51, 1'b0, 1'b0);

        // Backpressure in DONE with a competing request
        issue(8'h12, 8'h34, 1'b0);
        wait_valid(lows);
        @(posedge clk); #1;
        a = 8'h11; b = 8'h22; sub = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_result", result, 8'h46);
            chk("bp_cout", cout, 0);
            chk("bp_overflow", overflow, 0);
            chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk); #1; out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        @(negedge clk);
        chk("bp_idle_in_ready", in_ready, 1);
        chk("bp_idle_out_valid", out_valid, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(lows);
        chk("bp_next_latency", lows, W);
        chk("bp_next_result", result, 8'h33);
        release_result();

        // Random sweep with gaps and backpressure
        target = n_done + 1000;
        issued = 0;
        for (int c = 0; c < 40000 && n_done < target; c++) begin
            @(posedge clk); #1;
            if (in_valid && last_acc) in_valid = 1'b0;
            if (!in_valid && issued < 1000 && $urandom_range(0, 2) != 0) begin
                a        = W'($urandom);
                b        = W'($urandom);
                sub      = 1'($urandom_range(0, 1));
                in_valid = 1'b1;
                issued++;
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("sweep_done", n_done, target);
        chk("sweep_issued", issued, 1000);
        chk("no_lost_or_dup", n_acc - n_abort, n_done);
        chk("aborted_count", n_abort, 1);
        chk("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_addsub_ctrl

// File: doc/serial_addsub_ctrl.md
Name: serial_addsub_ctrl

Overview:
- Bit-serial add/subtract engine that sequences the team's existing single-bit full_adder cell over WIDTH cycles. It produces a WIDTH-bit sum or difference with carry-out and signed overflow.
- Sits beside the core ALU as the area-minimal arithmetic option for multi-cycle ops.
- Operands are accepted and results returned through valid/ready handshakes.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 2..64.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  1 = A-B, 0 = A+B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  sum/difference.
- cout  output  1  carry-out of MSB; for sub, 1 = no borrow.
- overflow  output  1  signed two's-complement overflow.
- busy  output  1  high in RUN state.

Behaviour:
- FSM has three states: IDLE, RUN, DONE.
- Reset (async, any state) forces:
  - state=IDLE, bit counter=0, carry reg=0.
  - Shift registers and result=0; cout=0, overflow=0.
  - in_ready=1, out_valid=0, busy=0.
- An operation aborted by reset is lost, with no partial result.
- IDLE:
  - in_ready=1.
  - On in_valid at a clk edge: load A into the A shift register and (sub ? ~b : b) into the B shift register, set carry reg=sub, counter=0, go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each edge: full_adder(a=A[0], b=B[0], cin=carry) runs.
  - The sum bit shifts into the result MSB as the result register shifts right. A and B shift right. Carry reg takes the full_adder cout.
  - On the edge where counter==WIDTH-1, record overflow = carry-in XOR carry-out of that bit and cout = full_adder cout, then go to DONE. Otherwise counter increments.
- DONE:
  - out_valid=1; result, cout and overflow are stable until the handshake.
  - On out_ready, go to IDLE; out_valid drops the next cycle.
  - out_ready held low leaves result held indefinitely.
- Latency:
  - out_valid rises exactly WIDTH cycles after the accepting edge.
  - Minimum issue interval is WIDTH+2 cycles (accept, WIDTH bits, DONE, back to IDLE).
- Ignored inputs:
  - in_valid while not IDLE is ignored; the requester must hold it.
  - Operand changes after acceptance do not affect the in-flight op.
- out_ready in IDLE or RUN is ignored.
- Arithmetic: result = (A + B + 0) or (A + ~B + 1) mod 2^WIDTH.
- Counter width is $clog2(WIDTH). The counter never wraps past WIDTH-1 and is reset to 0 on each acceptance.
- result is zero in IDLE after reset and retains the last value after a handshake.

Decomposition:
- Shared package arith_pkg holds:
  - typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} serial_state_t.
  - Constant OP_ADD=1'b0, OP_SUB=1'b1.
- The only sub-module is the existing full_adder, instantiated once. All sequencing, shift registers and the counter live in serial_addsub_ctrl.

Test Plan:
- Bench runs with WIDTH=8.
- Reset mid-RUN: rst pulse after 3 bit-cycles -> immediately in_ready=1, out_valid=0, busy=0, result=0x00; the next op completes correctly.
- Add with overflow: a=0x7F, b=0x01, sub=0 -> after 8 cycles result=0x80, cout=0, overflow=1.
- Add with carry wrap: a=0xFF, b=0x01, sub=0 -> result=0x00, cout=1, overflow=0; out_valid exactly 8 cycles after acceptance.
- Subtract: a=0x05, b=0x07, sub=1 -> result=0xFE, cout=0 (borrow), overflow=0. Then a=0x80, b=0x01, sub=1 -> result=0x7F, cout=1, overflow=1.
- Backpressure: hold out_ready=0 for 20 cycles in DONE -> result/flags stable, in_ready=0, new in_valid with a=0x11 ignored. Release out_ready -> IDLE next cycle.
- Random sweep: 1000 random a/b/sub operations with random in_valid/out_ready gaps -> every result, cout and overflow matches the reference model, and no operation is lost or duplicated.
